// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing the single-port main RAM between
// the CPU core and the debug/loader port.
//
// One access is in flight at a time. A winning request is captured into
// registered RAM controls, the winner sees a one-cycle gnt pulse, and for
// reads the arbiter waits out the fixed RAM latency before returning the data
// with a one-cycle rvalid pulse. Read data is held until that port's next read.
//
// Parameters:
//   ADDR_W  RAM address width
//   DATA_W  data width
//   RD_LAT  cycles from address-driven cycle to RAM read data valid (>= 1)
//
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   cpu_req/we/addr/wdata             CPU request and payload (held until gnt)
//   cpu_gnt, cpu_rvalid, cpu_rdata    CPU grant pulse, read-valid pulse, held data
//   dbg_*                             same set for the debug/loader port
//   ram_addr, ram_wren, ram_wdata     registered RAM controls
//   ram_rdata                         RAM read data, RD_LAT cycles after address
module mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              owner_q, owner_d;        // 1 = dbg owns the access
   logic              last_win_q, last_win_d;  // 1 = dbg won last arbitration
   logic              we_q, we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              ram_wren_q, ram_wren_d;
   logic              cpu_gnt_q, cpu_gnt_d;
   logic              dbg_gnt_q, dbg_gnt_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic              dbg_rvalid_q, dbg_rvalid_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              win_dbg;

   // dbg wins when it is alone, or on a tie when the CPU won last time.
   assign win_dbg = dbg_req && (!cpu_req || !last_win_q);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_win_d   = last_win_q;
      we_d         = we_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_wren_d   = 1'b0;
      cpu_gnt_d    = 1'b0;
      dbg_gnt_d    = 1'b0;
      cpu_rvalid_d = 1'b0;
      dbg_rvalid_d = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;

      unique case (state_q)
         StIdle: begin
            if (cpu_req || dbg_req) begin
               state_d     = StIssue;
               owner_d     = win_dbg;
               last_win_d  = win_dbg;
               we_d        = win_dbg ? dbg_we : cpu_we;
               ram_addr_d  = win_dbg ? dbg_addr : cpu_addr;
               ram_wdata_d = win_dbg ? dbg_wdata : cpu_wdata;
               // gnt and wren are registered so they line up with the ISSUE cycle
               ram_wren_d  = win_dbg ? dbg_we : cpu_we;
               cpu_gnt_d   = !win_dbg;
               dbg_gnt_d   = win_dbg;
            end
         end
         StIssue: begin
            if (we_q) begin
               state_d = StIdle;
            end else begin
               state_d = StWait;
               cnt_d   = CntW'(RD_LAT);
            end
         end
         StWait: begin
            if (cnt_q == CntW'(1)) begin
               state_d = StIdle;
               if (owner_q) begin
                  dbg_rvalid_d = 1'b1;
                  dbg_rdata_d  = ram_rdata;
               end else begin
                  cpu_rvalid_d = 1'b1;
                  cpu_rdata_d  = ram_rdata;
               end
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         owner_q      <= 1'b0;
         last_win_q   <= 1'b1;  // CPU wins the first tie
         we_q         <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         ram_wren_q   <= 1'b0;
         cpu_gnt_q    <= 1'b0;
         dbg_gnt_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_win_q   <= last_win_d;
         we_q         <= we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_wren_q   <= ram_wren_d;
         cpu_gnt_q    <= cpu_gnt_d;
         dbg_gnt_q    <= dbg_gnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dbg_rvalid_q <= dbg_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

   assign cpu_gnt    = cpu_gnt_q;
   assign dbg_gnt    = dbg_gnt_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign dbg_rvalid = dbg_rvalid_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign dbg_rdata  = dbg_rdata_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wren   = ram_wren_q;
   assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked every cycle against a transaction-level model of the arbiter and a
// simple latency-pipelined RAM model.
module tb_mem_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int RdLat = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cpu_req, cpu_we, dbg_req, dbg_we;
   logic [AW-1:0] cpu_addr, dbg_addr;
   logic [DW-1:0] cpu_wdata, dbg_wdata;
   logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [DW-1:0] cpu_rdata, dbg_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_wren;
   logic [DW-1:0] ram_wdata, ram_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RdLat)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata (cpu_rdata),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_gnt   (dbg_gnt),
      .dbg_rvalid(dbg_rvalid),
      .dbg_rdata (dbg_rdata),
      .ram_addr  (ram_addr),
      .ram_wren  (ram_wren),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // RAM model: 64 words, read data appears RdLat cycles after the address.
   logic          ram_clr;
   logic [DW-1:0] ram  [0:63];
   logic [DW-1:0] pipe [0:RdLat-1];
   assign ram_rdata = pipe[RdLat-1];

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 64; i++) ram[i] <= '0;
      end else if (ram_wren) begin
         ram[ram_addr[7:2]] <= ram_wdata;
      end
      pipe[0] <= ram[ram_addr[7:2]];
      for (int i = 1; i < RdLat; i++) pipe[i] <= pipe[i-1];
   end

   // Transaction-level model state; expectations describe the cycle after edge e.
   int            e = 0;
   int            n_vec = 0;
   int            n_err = 0;
   bit            mdl_ok = 1'b0;
   int            free_edge, rv_edge;
   bit            rv_owner, last_win;
   logic [DW-1:0] rv_data;
   logic [DW-1:0] shadow [0:63];
   logic          m_cpu_gnt, m_dbg_gnt, m_cpu_rv, m_dbg_rv, m_wren;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_cpu_rd, m_dbg_rd;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: actual %0h required %0h", name, e, act, exp);
      end
   endtask

   task automatic model_step();
      bit            win, we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      e++;
      m_cpu_gnt = 1'b0;
      m_dbg_gnt = 1'b0;
      m_cpu_rv  = 1'b0;
      m_dbg_rv  = 1'b0;
      m_wren    = 1'b0;
      if (!reset_n) begin
         mdl_ok    = 1'b1;
         free_edge = e + 1;
         rv_edge   = -1;
         last_win  = 1'b1;
         m_addr    = '0;
         m_wdata   = '0;
         m_cpu_rd  = '0;
         m_dbg_rd  = '0;
         return;
      end
      if (!mdl_ok) return;
      if (e == rv_edge) begin
         if (rv_owner) begin
            m_dbg_rv = 1'b1;
            m_dbg_rd = rv_data;
         end else begin
            m_cpu_rv = 1'b1;
            m_cpu_rd = rv_data;
         end
         rv_edge = -1;
      end
      if (e >= free_edge && (cpu_req || dbg_req)) begin
         win      = (cpu_req && dbg_req) ? !last_win : dbg_req;
         last_win = win;
         we       = win ? dbg_we : cpu_we;
         a        = win ? dbg_addr : cpu_addr;
         d        = win ? dbg_wdata : cpu_wdata;
         m_addr   = a;
         m_wdata  = d;
         m_wren   = we;
         if (win) m_dbg_gnt = 1'b1;
         else     m_cpu_gnt = 1'b1;
         if (we) begin
            shadow[a[7:2]] = d;
            free_edge      = e + 2;
         end else begin
            rv_edge   = e + RdLat + 1;
            rv_owner  = win;
            rv_data   = shadow[a[7:2]];
            free_edge = e + RdLat + 2;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (mdl_ok) begin
            chk("cpu_gnt", cpu_gnt, m_cpu_gnt);
            chk("dbg_gnt", dbg_gnt, m_dbg_gnt);
            chk("cpu_rvalid", cpu_rvalid, m_cpu_rv);
            chk("dbg_rvalid", dbg_rvalid, m_dbg_rv);
            chk("cpu_rdata", cpu_rdata, m_cpu_rd);
            chk("dbg_rdata", dbg_rdata, m_dbg_rd);
            chk("ram_wren", ram_wren, m_wren);
            chk("ram_addr", ram_addr, m_addr);
            chk("ram_wdata", ram_wdata, m_wdata);
            chk("cpu_gnt_rvalid_excl", cpu_gnt & cpu_rvalid, 1'b0);
            chk("dbg_gnt_rvalid_excl", dbg_gnt & dbg_rvalid, 1'b0);
         end
      end
   end

   function automatic logic gnt_of(input bit p);
      return p ? dbg_gnt : cpu_gnt;
   endfunction

   function automatic logic rv_of(input bit p);
      return p ? dbg_rvalid : cpu_rvalid;
   endfunction

   task automatic set_port(input bit p, input bit req, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p) begin
         dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
      end else begin
         cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      end
   endtask

   // Single access on one port; gl/rl count cycles from request to gnt/rvalid.
   task automatic access(input bit p, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int gl, output int rl);
      set_port(p, 1'b1, we, a, d);
      gl = 0;
      do begin tick(); gl++; end while (!gnt_of(p) && gl < 50);
      chk(p ? "dbg_gnt_seen" : "cpu_gnt_seen", gnt_of(p), 1'b1);
      set_port(p, 1'b0, 1'b0, '0, '0);
      rl = 0;
      if (!we) begin
         rl = gl;
         do begin tick(); rl++; end while (!rv_of(p) && rl < 50);
         chk(p ? "dbg_rvalid_seen" : "cpu_rvalid_seen", rv_of(p), 1'b1);
      end
   endtask

   task automatic rand_port(input bit p);
      bit req;
      req = p ? dbg_req : cpu_req;
      if (gnt_of(p)) begin
         if ($urandom_range(1, 0) == 1)
            set_port(p, 1'b1, 1'($urandom_range(1, 0)), {24'd0, 6'($urandom_range(63, 0)), 2'b00},
                     $urandom);
         else
            set_port(p, 1'b0, 1'b0, '0, '0);
      end else if (!req) begin
         if ($urandom_range(2, 0) == 0)
            set_port(p, 1'b1, 1'($urandom_range(1, 0)), {24'd0, 6'($urandom_range(63, 0)), 2'b00},
                     $urandom);
      end else if ($urandom_range(49, 0) == 0) begin
         set_port(p, 1'b0, 1'b0, '0, '0);  // withdrawn request
      end
   endtask

   int gl, rl, ng, k, cnt;
   int order [0:7];
   int gcyc  [0:7];

   initial begin
      reset_n = 1'b0;
      ram_clr = 1'b1;
      set_port(1'b0, 1'b0, 1'b0, '0, '0);
      set_port(1'b1, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 64; i++) shadow[i] = '0;
      tick();
      tick();
      ram_clr = 1'b0;
      reset_n = 1'b1;

      // Idle after reset.
      cnt = 0;
      repeat (10) begin tick(); cnt += int'(ram_wren); end
      chk("idle_wren_count", cnt, 0);
      chk("idle_cpu_rdata", cpu_rdata, 0);
      chk("idle_ram_addr", ram_addr, 0);

      // CPU write then read back.
      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, gl, rl);
      chk("wr_gnt_lat", gl, 1);
      chk("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
      repeat (2) tick();
      access(1'b0, 1'b0, 32'h10, 32'h0, gl, rl);
      chk("rd_gnt_lat", gl, 1);
      chk("rd_rvalid_lat", rl, 4);
      chk("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      chk("rd_dbg_rdata_untouched", dbg_rdata, 0);
      repeat (2) tick();

      // Contended reads from reset: CPU first, then strict alternation.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      set_port(1'b0, 1'b1, 1'b0, 32'h10, '0);
      set_port(1'b1, 1'b1, 1'b0, 32'h40, '0);
      ng = 0;
      k  = 0;
      while (ng < 8 && k < 200) begin
         tick();
         k++;
         if (cpu_gnt || dbg_gnt) begin
            order[ng] = int'(dbg_gnt);
            gcyc[ng]  = k;
            ng++;
            if (dbg_gnt) dbg_addr = dbg_addr + 4;
            else         cpu_addr = cpu_addr + 4;
         end
      end
      set_port(1'b0, 1'b0, 1'b0, '0, '0);
      set_port(1'b1, 1'b0, 1'b0, '0, '0);
      chk("alt_count", ng, 8);
      for (int i = 0; i < ng; i++) chk("alt_order", order[i], i % 2);
      for (int i = 1; i < ng; i++) chk("alt_spacing", gcyc[i] - gcyc[i-1], 4);
      repeat (RdLat + 4) tick();

      // Loader burst on dbg, then CPU readback.
      set_port(1'b1, 1'b1, 1'b1, 32'h0, 32'h1);
      ng = 0;
      k  = 0;
      while (ng < 8 && k < 100) begin
         tick();
         k++;
         if (dbg_gnt) begin
            gcyc[ng] = k;
            ng++;
            if (ng < 8) set_port(1'b1, 1'b1, 1'b1, AW'(ng * 4), DW'(ng + 1));
            else        set_port(1'b1, 1'b0, 1'b0, '0, '0);
         end
      end
      set_port(1'b1, 1'b0, 1'b0, '0, '0);
      chk("burst_count", ng, 8);
      for (int i = 1; i < ng; i++) chk("burst_spacing", gcyc[i] - gcyc[i-1], 2);
      tick();
      for (int i = 0; i < 8; i++) begin
         access(1'b0, 1'b0, AW'(i * 4), '0, gl, rl);
         chk("burst_readback", cpu_rdata, i + 1);
      end
      tick();

      // Reset during the WAIT phase of a dbg read.
      set_port(1'b1, 1'b1, 1'b0, 32'h18, '0);
      k = 0;
      do begin tick(); k++; end while (!dbg_gnt && k < 50);
      chk("rst_dbg_gnt_seen", dbg_gnt, 1'b1);
      set_port(1'b1, 1'b0, 1'b0, '0, '0);
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_dbg_rdata", dbg_rdata, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      cnt = 0;
      repeat (8) begin tick(); cnt += int'(dbg_rvalid); end
      chk("rst_no_dbg_rvalid", cnt, 0);
      access(1'b0, 1'b0, 32'h10, '0, gl, rl);
      chk("rst_cpu_rd_lat", rl, 4);
      chk("rst_cpu_rdata_after", cpu_rdata, 5);
      tick();

      // One-cycle CPU pulse while a dbg read is waiting.
      set_port(1'b1, 1'b1, 1'b0, 32'h1C, '0);
      k = 0;
      do begin tick(); k++; end while (!dbg_gnt && k < 50);
      chk("pulse_dbg_gnt_seen", dbg_gnt, 1'b1);
      set_port(1'b1, 1'b0, 1'b0, '0, '0);
      tick();
      set_port(1'b0, 1'b1, 1'b0, 32'h0, '0);
      tick();
      set_port(1'b0, 1'b0, 1'b0, '0, '0);
      cnt = 0;
      repeat (8) begin tick(); cnt += int'(cpu_gnt); end
      chk("pulse_no_cpu_gnt", cnt, 0);
      chk("pulse_dbg_rdata", dbg_rdata, 8);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         tick();
         reset_n = ($urandom_range(399, 0) != 0);
         rand_port(1'b0);
         rand_port(1'b1);
      end
      reset_n = 1'b1;
      set_port(1'b0, 1'b0, 1'b0, '0, '0);
      set_port(1'b1, 1'b0, 1'b0, '0, '0);
      repeat (8) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port main RAM between the CPU core (instruction fetch and load/store, already multiplexed by the core's `ram_addr_src` select) and a debug/loader port used to load programs and inspect memory. It serialises accesses with round-robin fairness, drives the RAM address/write controls from registers, and tracks the fixed RAM read latency. Each requester gets a one-cycle grant pulse and a one-cycle read-valid pulse with held read data.

## Interface
- `ADDR_W`, default 32: RAM address width.
- `DATA_W`, default 32: data width.
- `RD_LAT`, default 2: cycles from address-driven cycle to RAM read data valid; must be ≥1.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; held until `cpu_gnt`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  access address.
- `cpu_wdata`  in  DATA_W  write data.
- `cpu_gnt`  out  1  one-cycle pulse: CPU access issued to RAM this cycle.
- `cpu_rvalid`  out  1  one-cycle pulse: `cpu_rdata` updated.
- `cpu_rdata`  out  DATA_W  last completed CPU read data, held.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as the `cpu_*` signals, for the debug/loader port.
- `ram_addr`  out  ADDR_W  registered RAM address.
- `ram_wren`  out  1  registered RAM write enable.
- `ram_wdata`  out  DATA_W  registered RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, valid `RD_LAT` cycles after address.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: sample `cpu_req`/`dbg_req` each edge.
  - No request: stay in IDLE.
  - One request: that port wins.
  - Both requesting: the port not in `last_win` wins.
  - On a win: register winner's addr/we/wdata into `ram_*`, set `owner`, set `last_win` = winner, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Winner's `*_gnt` = 1; `ram_wren` = captured `we`.
  - Write: next state IDLE.
  - Read: load wait counter with `RD_LAT`, next state WAIT.
- WAIT:
  - `ram_addr` held, `ram_wren` = 0; counter decrements each cycle.
  - On the edge ending the final WAIT cycle (counter = 1): capture `ram_rdata` into the owner's `*_rdata`, set the owner's `*_rvalid` for the next cycle, go to IDLE.
- Requester rules:
  - Addr/we/wdata are captured at the IDLE→ISSUE edge; the requester must hold `req` and its payload until it sees `gnt`, and drop `req` after `gnt` unless issuing another access.
  - A request withdrawn before it is sampled in IDLE is ignored.
- The non-owning port's `rdata` is never modified.
- `ram_wdata`/`ram_addr` keep their last value while IDLE; `ram_wren` = 0 in every state except a write ISSUE.

## Timing
- Reset values: state IDLE, `last_win` = dbg (CPU wins the first tie), all `gnt`/`rvalid`/`ram_wren` = 0, `ram_addr`/`ram_wdata`/`cpu_rdata`/`dbg_rdata` = 0.
- Reset mid-operation aborts any access; a pending read produces no `rvalid`.
- Read, request first sampled at edge E0:
  - `gnt` in cycle 1.
  - WAIT in cycles 2..`RD_LAT`+1.
  - `rvalid` and new `rdata` in cycle `RD_LAT`+2; the arbiter is IDLE in that cycle.
- Write: `gnt` and `ram_wren` in cycle 1; IDLE in cycle 2.
- Minimum issue spacing: write-to-next 2 cycles; read-to-next `RD_LAT`+2 cycles.
- With both ports continuously requesting, grants strictly alternate.
- Any `gnt` and `rvalid` are never high together for the same port in the same cycle.

## Test plan
- Reset, then idle 10 cycles: all outputs 0, `ram_wren` never asserted.
- CPU write addr 0x10 data 0xDEADBEEF, then CPU read 0x10 (RAM model, `RD_LAT`=2): `cpu_gnt` pulses; `cpu_rvalid` 4 cycles after read-request sample with `cpu_rdata` = 0xDEADBEEF; `dbg_rdata` stays 0.
- Both ports request reads together from reset: CPU granted first, dbg next; alternation holds for 8 consecutive contended accesses.
- Dbg writes 0x1..0x8 to 0x0..0x1C (loader burst) while CPU is idle: 8 grants, 2 cycles apart; readback by CPU matches.
- `reset_n` asserted in the WAIT cycle of a dbg read: no `dbg_rvalid`; outputs return to reset values; next CPU read completes normally.
- CPU `req` pulsed for one cycle while a dbg read is in WAIT: request ignored, no `cpu_gnt`.
